// File: rtl/ppt_pkg.sv
// ---------------------------------------------------------------------------
// ppt_pkg
// Shared definitions for the programmable pulse train (PPT) sequencer:
// default field widths, the minimum legal period, and the FSM state type.
// ---------------------------------------------------------------------------
package ppt_pkg;

  localparam int PPT_CW         = 16;  // period/width/count/pulse-counter width
  localparam int PPT_DIVW       = 5;   // prescaler field width
  localparam int PPT_MIN_PERIOD = 2;   // smallest period that leaves room for a low phase

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } ppt_state_e;

endpackage

// File: rtl/ppt_if.sv
// ---------------------------------------------------------------------------
// ppt_if
// Register-map side of the PPT sequencer: configuration fields and start/stop
// strobes going in, status and pulse output coming back.
//   master : register map (drives config/strobes, reads status)
//   slave  : ppt_sequencer
// Signals:
//   start, stop   1-cycle strobes
//   clk_div       prescale, one tick every clk_div+1 clocks
//   period, width pulse period / high time in ticks
//   count         number of pulses to emit
//   pulse_out     registered pulse train
//   busy, done, cfg_err, count_done  status
// ---------------------------------------------------------------------------
interface ppt_if
  import ppt_pkg::*;
#(
  parameter int CW   = PPT_CW,
  parameter int DIVW = PPT_DIVW
);

  logic            start;
  logic            stop;
  logic [DIVW-1:0] clk_div;
  logic [CW-1:0]   period;
  logic [CW-1:0]   width;
  logic [CW-1:0]   count;

  logic            pulse_out;
  logic            busy;
  logic            done;
  logic            cfg_err;
  logic [CW-1:0]   count_done;

  modport master (
    output start, stop, clk_div, period, width, count,
    input  pulse_out, busy, done, cfg_err, count_done
  );

  modport slave (
    input  start, stop, clk_div, period, width, count,
    output pulse_out, busy, done, cfg_err, count_done
  );

endinterface

// File: rtl/ppt_prescaler.sv
// ---------------------------------------------------------------------------
// ppt_prescaler
// Divides clk down to a 1-clock tick strobe every div+1 clocks. While clr is
// high the counter is held at zero, so the first tick after clr drops arrives
// exactly div+1 clocks later.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       hold counter at zero, suppress tick
//   div       divide value (0 -> tick every clock)
//   tick      1-clock strobe
// ---------------------------------------------------------------------------
module ppt_prescaler
  import ppt_pkg::*;
#(
  parameter int DIVW = PPT_DIVW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt_q, cnt_d;

  always_comb begin
    // >= rather than == so a counter that is somehow past div still wraps.
    tick  = !clr && (cnt_q >= div);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ppt_sequencer.sv
// ---------------------------------------------------------------------------
// ppt_sequencer
// Emits one programmable pulse train of `count` pulses. Each pulse period is
// `period` ticks with the output high for the first `width` ticks; a tick is
// every clk_div+1 clocks. Configuration is latched on an accepted start and
// the live inputs are ignored until the train ends.
//   IDLE -> ARM (1 clk, prescaler/phase reset) -> RUN -> IDLE
// A start with start at edge N gives the first rising edge of pulse_out at
// edge N+2. The train ends on the falling edge of the last pulse; the low
// tail of the final period is not waited for.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       ppt_if.slave (config, start/stop, pulse_out and status)
// Build option:
//   PPT_CONTINUOUS_EN  when defined, count==0 runs until stop (done never
//                      set); when undefined, count==0 is a config error.
// ---------------------------------------------------------------------------
module ppt_sequencer
  import ppt_pkg::*;
#(
  parameter int CW   = PPT_CW,
  parameter int DIVW = PPT_DIVW
) (
  input  logic  clk,
  input  logic  rst,
  ppt_if.slave  bus
);

  ppt_state_e      state_q, state_d;
  logic [CW-1:0]   period_q, period_d;
  logic [CW-1:0]   width_q, width_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [CW-1:0]   phase_q, phase_d;
  logic [CW-1:0]   count_done_q, count_done_d;
  logic            pulse_q, pulse_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cfg_err_q, cfg_err_d;

  logic            tick;
  logic            cfg_bad;
  logic            count_bad;
  logic            finite;
  logic            pulse_raw;
  logic            fall;
  logic            last;
  logic [CW-1:0]   count_inc;

  ppt_prescaler #(.DIVW(DIVW)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != RUN),
    .div  (div_q),
    .tick (tick)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    width_d      = width_q;
    count_d      = count_q;
    div_d        = div_q;
    phase_d      = phase_q;
    count_done_d = count_done_q;
    pulse_d      = 1'b0;
    done_d       = done_q;
    cfg_err_d    = cfg_err_q;
    pulse_raw    = 1'b0;
    fall         = 1'b0;
    last         = 1'b0;

    cfg_bad   = (bus.period < CW'(PPT_MIN_PERIOD)) || (bus.width == '0);
`ifdef PPT_CONTINUOUS_EN
    count_bad = 1'b0;
    finite    = (count_q != '0);
`else
    count_bad = (bus.count == '0);
    finite    = 1'b1;
`endif

    count_inc = (count_done_q == '1) ? count_done_q : count_done_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_bad || count_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            period_d     = bus.period;
            // An over-long width is clamped so the pulse still has a low phase.
            width_d      = (bus.width >= bus.period) ? bus.period - 1'b1 : bus.width;
            count_d      = bus.count;
            div_d        = bus.clk_div;
            done_d       = 1'b0;
            cfg_err_d    = 1'b0;
            count_done_d = '0;
            state_d      = ARM;
          end
        end
      end

      ARM: begin
        phase_d = '0;
        state_d = bus.stop ? IDLE : RUN;
      end

      RUN: begin
        // pulse_out lags phase by one clock; a fall is seen one edge early here.
        pulse_raw = (phase_q < width_q);
        fall      = pulse_q && !pulse_raw;
        last      = fall && finite && (count_inc == count_q);
        if (last) begin
          // Completion outranks a coincident stop.
          count_done_d = count_inc;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else if (bus.stop) begin
          state_d = IDLE;
        end else begin
          pulse_d = pulse_raw;
          if (fall) count_done_d = count_inc;
          if (tick) phase_d = (phase_q == period_q - 1'b1) ? '0 : phase_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: the latched configuration is reset along with the control state;
  // it is only a few words, and a defined value keeps reset behaviour
  // reproducible in simulation and on silicon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      period_q     <= '0;
      width_q      <= '0;
      count_q      <= '0;
      div_q        <= '0;
      phase_q      <= '0;
      count_done_q <= '0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      width_q      <= width_d;
      count_q      <= count_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      count_done_q <= count_done_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.pulse_out  = pulse_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.count_done = count_done_q;

endmodule

// File: tb/tb_ppt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ppt_sequencer
// Directed bench for ppt_sequencer. Inputs change and outputs are sampled on
// the falling clock edge; expected latencies and durations are hand-derived
// from clk_div/period/width/count.
// ---------------------------------------------------------------------------
module tb_ppt_sequencer;
  import ppt_pkg::*;

  logic clk = 1'b0;
  logic rst;

  ppt_if #(.CW(PPT_CW), .DIVW(PPT_DIVW)) bus ();

  ppt_sequencer #(.CW(PPT_CW), .DIVW(PPT_DIVW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Caller sits on a falling edge; start is sampled on the next rising edge.
  task automatic strobe_start(input logic [PPT_DIVW-1:0] div, input logic [PPT_CW-1:0] per,
                              input logic [PPT_CW-1:0] wid, input logic [PPT_CW-1:0] cnt,
                              input logic with_stop);
    bus.clk_div = div;
    bus.period  = per;
    bus.width   = wid;
    bus.count   = cnt;
    bus.start   = 1'b1;
    bus.stop    = with_stop;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
  endtask

  task automatic strobe_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  // Counts falling edges until pulse_out reaches lvl (bounded).
  task automatic wait_level(input logic lvl, input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pulse_out !== lvl && n < max_cyc);
    if (bus.pulse_out !== lvl) check("wait_level_timeout", {31'd0, bus.pulse_out}, {31'd0, lvl});
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clk_div = '0;
    bus.period = '0; bus.width = '0; bus.count = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pulse", bus.pulse_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_count_done", bus.count_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: div 0, period 4, width 1, count 3
    strobe_start(5'd0, 16'd4, 16'd1, 16'd3, 1'b0);
    check("t1_busy", bus.busy, 1);
    check("t1_pulse_arm", bus.pulse_out, 0);
    wait_level(1'b1, 20, n);
    check("t1_rise_latency", n, 2);
    for (int p = 0; p < 3; p++) begin
      wait_level(1'b0, 100, n);
      check("t1_high", n, 1);
      if (p < 2) begin
        check("t1_count_done", bus.count_done, p + 1);
        check("t1_busy_mid", bus.busy, 1);
        wait_level(1'b1, 100, n);
        check("t1_low", n, 3);
      end
    end
    check("t1_done", bus.done, 1);
    check("t1_busy_end", bus.busy, 0);
    check("t1_count_done_end", bus.count_done, 3);

    // 2: div 3, period 10, width 12 (clamped to 9), count 2
    strobe_start(5'd3, 16'd10, 16'd12, 16'd2, 1'b0);
    check("t2_done_cleared", bus.done, 0);
    check("t2_count_cleared", bus.count_done, 0);
    check("t2_no_cfg_err", bus.cfg_err, 0);
    wait_level(1'b1, 20, n);
    check("t2_rise_latency", n, 2);
    wait_level(1'b0, 200, n);
    check("t2_high1", n, 36);
    wait_level(1'b1, 200, n);
    check("t2_low1", n, 4);
    wait_level(1'b0, 200, n);
    check("t2_high2", n, 36);
    check("t2_done", bus.done, 1);
    check("t2_count_done", bus.count_done, 2);
    check("t2_busy", bus.busy, 0);

    // 3: period 8, width 4, count 100; stop after the 3rd rise
    strobe_start(5'd0, 16'd8, 16'd4, 16'd100, 1'b0);
    wait_level(1'b1, 20, n);
    check("t3_rise_latency", n, 2);
    for (int r = 0; r < 2; r++) begin
      wait_level(1'b0, 100, n);
      check("t3_high", n, 4);
      wait_level(1'b1, 100, n);
      check("t3_low", n, 4);
    end
    strobe_stop();
    check("t3_stop_pulse", bus.pulse_out, 0);
    check("t3_stop_busy", bus.busy, 0);
    check("t3_stop_done", bus.done, 0);
    check("t3_stop_count", bus.count_done, 2);
    repeat (10) @(negedge clk);
    check("t3_idle_pulse", bus.pulse_out, 0);
    check("t3_frozen_count", bus.count_done, 2);
    // start and stop together in IDLE: start is taken
    strobe_start(5'd0, 16'd4, 16'd2, 16'd1, 1'b1);
    check("t3_restart_busy", bus.busy, 1);
    check("t3_restart_count", bus.count_done, 0);
    wait_level(1'b1, 20, n);
    check("t3_restart_rise", n, 2);
    wait_level(1'b0, 100, n);
    check("t3_restart_high", n, 2);
    check("t3_restart_done", bus.done, 1);
    check("t3_restart_count_end", bus.count_done, 1);
    check("t3_restart_busy_end", bus.busy, 0);

    // 4: configuration errors
    strobe_start(5'd0, 16'd1, 16'd1, 16'd1, 1'b0);
    check("t4_period1_err", bus.cfg_err, 1);
    check("t4_period1_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    check("t4_still_idle", bus.busy, 0);
    check("t4_no_pulse", bus.pulse_out, 0);
    strobe_start(5'd0, 16'd4, 16'd0, 16'd1, 1'b0);
    check("t4_width0_err", bus.cfg_err, 1);
    check("t4_width0_busy", bus.busy, 0);
`ifndef PPT_CONTINUOUS_EN
    strobe_start(5'd0, 16'd4, 16'd2, 16'd0, 1'b0);
    check("t6_count0_err", bus.cfg_err, 1);
    check("t6_count0_busy", bus.busy, 0);
`endif
    // minimum legal period clears cfg_err
    strobe_start(5'd0, 16'd2, 16'd1, 16'd2, 1'b0);
    check("t4_err_cleared", bus.cfg_err, 0);
    check("t4_valid_busy", bus.busy, 1);
    wait_level(1'b1, 20, n);
    check("t4_rise", n, 2);
    wait_level(1'b0, 20, n);
    check("t4_high", n, 1);
    wait_level(1'b1, 20, n);
    check("t4_low", n, 1);
    wait_level(1'b0, 20, n);
    check("t4_done", bus.done, 1);
    check("t4_count_done", bus.count_done, 2);

    // 5a: start during RUN is ignored
    strobe_start(5'd0, 16'd4, 16'd2, 16'd2, 1'b0);
    wait_level(1'b1, 20, n);
    strobe_start(5'd0, 16'd2, 16'd1, 16'd1, 1'b0);
    check("t5a_still_high", bus.pulse_out, 1);
    wait_level(1'b0, 20, n);
    check("t5a_high", n, 1);
    check("t5a_count1", bus.count_done, 1);
    check("t5a_busy", bus.busy, 1);
    check("t5a_no_err", bus.cfg_err, 0);
    wait_level(1'b1, 20, n);
    check("t5a_low", n, 2);
    wait_level(1'b0, 20, n);
    check("t5a_high2", n, 2);
    check("t5a_done", bus.done, 1);
    check("t5a_count2", bus.count_done, 2);

    // 5b: stop coinciding with the final fall -> completion wins
    strobe_start(5'd0, 16'd4, 16'd2, 16'd1, 1'b0);
    check("t5b_done_cleared", bus.done, 0);
    wait_level(1'b1, 20, n);
    @(negedge clk);
    strobe_stop();
    check("t5b_pulse", bus.pulse_out, 0);
    check("t5b_done", bus.done, 1);
    check("t5b_count", bus.count_done, 1);
    check("t5b_busy", bus.busy, 0);

    // 5c: reset mid-pulse drops pulse_out without a clock edge
    strobe_start(5'd0, 16'd8, 16'd4, 16'd5, 1'b0);
    wait_level(1'b1, 20, n);
    wait_level(1'b0, 20, n);
    wait_level(1'b1, 20, n);
    check("t5c_count_before", bus.count_done, 1);
    #2 rst = 1'b1;
    #1;
    check("t5c_async_pulse", bus.pulse_out, 0);
    check("t5c_async_busy", bus.busy, 0);
    check("t5c_async_count", bus.count_done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef PPT_CONTINUOUS_EN
    // 6: count 0 runs until stop
    strobe_start(5'd0, 16'd2, 16'd1, 16'd0, 1'b0);
    check("t6_no_err", bus.cfg_err, 0);
    for (int p = 0; p < 1001; p++) begin
      wait_level(1'b1, 10, n);
      wait_level(1'b0, 10, n);
    end
    check("t6_busy_running", bus.busy, 1);
    check("t6_count_running", bus.count_done, 1001);
    strobe_stop();
    check("t6_stop_busy", bus.busy, 0);
    check("t6_stop_done", bus.done, 0);
    check("t6_stop_count", bus.count_done, 1001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
